// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: program counter, instruction register and decoder for the
// 16-bit CPU. Holds the PC and IR, decodes the IR fields for the controller and
// register file, evaluates branch conditions against the status flags, and
// counts retired instruction loads.
module fetch_decode_unit #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      mdata,
    input  logic             loadir,
    input  logic             incp,
    input  logic             execb,
    input  logic             tsel,
    input  logic             msel,
    input  logic [1:0]       nsel,
    input  logic [PC_W-1:0]  c_addr,
    input  logic             z,
    input  logic             n,
    input  logic             v,
    output logic [2:0]       opcode,
    output logic [1:0]       op,
    output logic [2:0]       regnum,
    output logic [1:0]       shift,
    output logic [15:0]      sximm5,
    output logic [15:0]      sximm8,
    output logic [PC_W-1:0]  mem_addr,
    output logic [PC_W-1:0]  pc,
    output logic             br_taken,
    output logic [CNT_W-1:0] icount
);

    localparam logic [2:0] COND_B   = 3'b000;
    localparam logic [2:0] COND_BEQ = 3'b001;
    localparam logic [2:0] COND_BNE = 3'b010;
    localparam logic [2:0] COND_BLT = 3'b011;
    localparam logic [2:0] COND_BLE = 3'b100;

    localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Branch condition on the status flags; reserved codes are never taken.
    function automatic logic branch_cond(input logic [2:0] cond,
                                         input logic zf, input logic nf, input logic vf);
        logic t;
        case (cond)
            COND_B:   t = 1'b1;
            COND_BEQ: t = zf;
            COND_BNE: t = ~zf;
            COND_BLT: t = nf ^ vf;
            COND_BLE: t = (nf ^ vf) | zf;
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

    logic [15:0]      ir_r;
    logic [PC_W-1:0]  pc_r;
    logic             br_taken_r;
    logic [CNT_W-1:0] icount_r;

    logic [15:0]      ir_next_s;
    logic [PC_W-1:0]  pc_next_s;
    logic             br_taken_next_s;
    logic [CNT_W-1:0] icount_next_s;
    logic             cond_true_s;
    logic             take_branch_s;
    logic [15:0]      sximm8_s;

    assign sximm8_s      = {{8{ir_r[7]}}, ir_r[7:0]};
    assign cond_true_s   = branch_cond(ir_r[10:8], z, n, v);
    assign take_branch_s = execb & tsel & cond_true_s;

    // Next-state for IR, instruction counter, PC (branch beats increment) and branch flag.
    always_comb begin
        ir_next_s       = ir_r;
        icount_next_s   = icount_r;
        pc_next_s       = pc_r;
        br_taken_next_s = br_taken_r;

        if (loadir) begin
            ir_next_s     = mdata;
            icount_next_s = icount_r + CNT_ONE;
        end else begin
            ir_next_s     = ir_r;
            icount_next_s = icount_r;
        end

        // The PC already points past the branch, so the target is relative to PC+1.
        if (take_branch_s) begin
            pc_next_s = pc_r + sximm8_s[PC_W-1:0];
        end else if (incp) begin
            pc_next_s = pc_r + PC_ONE;
        end else begin
            pc_next_s = pc_r;
        end

        if (execb) begin
            br_taken_next_s = tsel & cond_true_s;
        end else begin
            br_taken_next_s = br_taken_r;
        end
    end

    // State registers; reset discards any branch pending in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir_r       <= 16'h0000;
            pc_r       <= RESET_PC;
            br_taken_r <= 1'b0;
            icount_r   <= '0;
        end else begin
            ir_r       <= ir_next_s;
            pc_r       <= pc_next_s;
            br_taken_r <= br_taken_next_s;
            icount_r   <= icount_next_s;
        end
    end

    // Register-number select for the register file.
    always_comb begin
        regnum = 3'b000;
        case (nsel)
            2'b00:   regnum = ir_r[10:8];
            2'b01:   regnum = ir_r[7:5];
            2'b10:   regnum = ir_r[2:0];
            2'b11:   regnum = ir_r[10:8];
            default: regnum = 3'b000;
        endcase
    end

    assign opcode   = ir_r[15:13];
    assign op       = ir_r[12:11];
    assign shift    = ir_r[4:3];
    assign sximm5   = {{11{ir_r[4]}}, ir_r[4:0]};
    assign sximm8   = sximm8_s;
    assign mem_addr = msel ? c_addr : pc_r;
    assign pc       = pc_r;
    assign br_taken = br_taken_r;
    assign icount   = icount_r;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: stimulus pushes expected values into
// a queue, a monitor on the falling edge pops and compares them.
module tb_fetch_decode_unit;

    localparam int PC_W  = 8;
    localparam int CNT_W = 4;

    localparam int S_PC = 0, S_ICNT = 1, S_OPC = 2, S_OP = 3, S_SX8 = 4,
                   S_SX5 = 5, S_BR = 6, S_MADDR = 7, S_REG = 8, S_SHIFT = 9;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        logic [15:0] ir;
        logic        zf;
        logic        nf;
        logic        vf;
        logic        tk;
    } br_vec_t;

    logic             clk;
    logic             reset_n;
    logic [15:0]      mdata;
    logic             loadir, incp, execb, tsel, msel;
    logic [1:0]       nsel;
    logic [PC_W-1:0]  c_addr;
    logic             z, n, v;
    logic [2:0]       opcode;
    logic [1:0]       op;
    logic [2:0]       regnum;
    logic [1:0]       shift;
    logic [15:0]      sximm5, sximm8;
    logic [PC_W-1:0]  mem_addr, pc;
    logic             br_taken;
    logic [CNT_W-1:0] icount;

    exp_t q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    logic [PC_W-1:0]  pc_m;
    logic [CNT_W-1:0] icnt_m;

    fetch_decode_unit #(.PC_W(PC_W), .RESET_PC(8'h00), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .mdata(mdata), .loadir(loadir), .incp(incp),
        .execb(execb), .tsel(tsel), .msel(msel), .nsel(nsel), .c_addr(c_addr),
        .z(z), .n(n), .v(v), .opcode(opcode), .op(op), .regnum(regnum),
        .shift(shift), .sximm5(sximm5), .sximm8(sximm8), .mem_addr(mem_addr),
        .pc(pc), .br_taken(br_taken), .icount(icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            S_PC:    return {24'h0, pc};
            S_ICNT:  return {28'h0, icount};
            S_OPC:   return {29'h0, opcode};
            S_OP:    return {30'h0, op};
            S_SX8:   return {16'h0, sximm8};
            S_SX5:   return {16'h0, sximm5};
            S_BR:    return {31'h0, br_taken};
            S_MADDR: return {24'h0, mem_addr};
            S_REG:   return {29'h0, regnum};
            S_SHIFT: return {30'h0, shift};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.sig);
            checks_total++;
            if (a === e.exp) checks_passed++;
            else $display("FAIL %s: got %0h expected %0h", e.name, a, e.exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string nm, input int sig, input logic [31:0] e);
        exp_t x;
        x.name = nm;
        x.sig  = sig;
        x.exp  = e;
        q.push_back(x);
    endtask

    task automatic load_ir(input logic [15:0] w);
        mdata  = w;
        loadir = 1'b1;
        tick();
        loadir = 1'b0;
        icnt_m = icnt_m + 4'd1;
    endtask

    task automatic do_branch();
        execb = 1'b1;
        tsel  = 1'b1;
        tick();
        execb = 1'b0;
        tsel  = 1'b0;
    endtask

    br_vec_t vecs[10];

    initial begin
        vecs[0] = '{16'h2201, 1'b0, 1'b0, 1'b0, 1'b1};  // BNE z=0
        vecs[1] = '{16'h2201, 1'b1, 1'b0, 1'b0, 1'b0};  // BNE z=1
        vecs[2] = '{16'h2401, 1'b0, 1'b1, 1'b0, 1'b1};  // BLE n!=v
        vecs[3] = '{16'h2401, 1'b1, 1'b0, 1'b0, 1'b1};  // BLE z
        vecs[4] = '{16'h2401, 1'b0, 1'b1, 1'b1, 1'b0};  // BLE none
        vecs[5] = '{16'h2301, 1'b0, 1'b0, 1'b1, 1'b1};  // BLT n!=v
        vecs[6] = '{16'h2301, 1'b0, 1'b1, 1'b1, 1'b0};  // BLT n==v
        vecs[7] = '{16'h2501, 1'b1, 1'b1, 1'b0, 1'b0};  // reserved 101
        vecs[8] = '{16'h2701, 1'b1, 1'b1, 1'b0, 1'b0};  // reserved 111
        vecs[9] = '{16'h2001, 1'b0, 1'b0, 1'b0, 1'b1};  // B

        reset_n = 1'b0; mdata = 16'h0000; loadir = 1'b0; incp = 1'b1;
        execb = 1'b0; tsel = 1'b0; msel = 1'b0; nsel = 2'b00; c_addr = 8'h00;
        z = 1'b0; n = 1'b0; v = 1'b0;

        // Reset held two cycles with incp asserted
        tick(); tick();
        reset_n = 1'b1; incp = 1'b0;
        pc_m = 8'h00; icnt_m = 4'd0;
        expect_val("rst_pc", S_PC, 32'h0);
        expect_val("rst_icount", S_ICNT, 32'h0);
        expect_val("rst_opcode", S_OPC, 32'h0);
        expect_val("rst_op", S_OP, 32'h0);
        expect_val("rst_sximm8", S_SX8, 32'h0);
        expect_val("rst_sximm5", S_SX5, 32'h0);
        expect_val("rst_br", S_BR, 32'h0);

        // Fetch
        load_ir(16'hD105);
        expect_val("fetch_opcode", S_OPC, 32'h6);
        expect_val("fetch_op", S_OP, 32'h2);
        expect_val("fetch_sximm8", S_SX8, 32'h0005);
        expect_val("fetch_sximm5", S_SX5, 32'h0005);
        expect_val("fetch_shift", S_SHIFT, 32'h0);
        expect_val("fetch_icount", S_ICNT, 32'h1);
        expect_val("fetch_pc_hold", S_PC, 32'h0);
        incp = 1'b1; tick(); incp = 1'b0;
        pc_m = 8'h01;
        expect_val("incp_pc", S_PC, 32'h1);
        expect_val("maddr_pc", S_MADDR, 32'h1);

        // BEQ at pc=4
        incp = 1'b1; repeat (3) tick(); incp = 1'b0;
        pc_m = 8'h04;
        expect_val("pc4", S_PC, 32'h4);
        load_ir(16'h2103);
        z = 1'b0; do_branch();
        expect_val("beq_nt_pc", S_PC, 32'h4);
        expect_val("beq_nt_br", S_BR, 32'h0);
        z = 1'b1; do_branch();
        pc_m = 8'h07;
        expect_val("beq_t_pc", S_PC, 32'h7);
        expect_val("beq_t_br", S_BR, 32'h1);
        z = 1'b0; do_branch();
        expect_val("beq_nt2_pc", S_PC, 32'h7);
        expect_val("beq_nt2_br", S_BR, 32'h0);

        // Condition table, imm=+1
        for (int i = 0; i < 10; i++) begin
            load_ir(vecs[i].ir);
            z = vecs[i].zf; n = vecs[i].nf; v = vecs[i].vf;
            do_branch();
            if (vecs[i].tk) pc_m = pc_m + 8'd1;
            expect_val($sformatf("cond%0d_pc", i), S_PC, {24'h0, pc_m});
            expect_val($sformatf("cond%0d_br", i), S_BR, {31'h0, vecs[i].tk});
        end
        z = 1'b0; n = 1'b0; v = 1'b0;
        expect_val("icount_after_table", S_ICNT, {28'h0, icnt_m});

        // Reset during a taken-branch cycle
        reset_n = 1'b0; execb = 1'b1; tsel = 1'b1;
        tick();
        reset_n = 1'b1; execb = 1'b0; tsel = 1'b0;
        pc_m = 8'h00; icnt_m = 4'd0;
        expect_val("rst_exb_pc", S_PC, 32'h0);
        expect_val("rst_exb_br", S_BR, 32'h0);
        expect_val("rst_exb_icount", S_ICNT, 32'h0);
        expect_val("rst_exb_opcode", S_OPC, 32'h0);

        // BLT backward with wrap
        incp = 1'b1; tick(); incp = 1'b0;
        load_ir(16'h23FE);
        expect_val("neg_sximm8", S_SX8, 32'hFFFE);
        expect_val("neg_sximm5", S_SX5, 32'hFFFE);
        expect_val("neg_shift", S_SHIFT, 32'h3);
        n = 1'b1; v = 1'b0; do_branch(); n = 1'b0;
        expect_val("blt_wrap_pc", S_PC, 32'hFF);
        expect_val("blt_wrap_br", S_BR, 32'h1);
        incp = 1'b1; tick(); incp = 1'b0;
        expect_val("incp_wrap_pc", S_PC, 32'h0);

        // Branch beats incp; execb without tsel
        incp = 1'b1; repeat (2) tick(); incp = 1'b0;
        load_ir(16'h2010);
        execb = 1'b1; tsel = 1'b1; incp = 1'b1;
        tick();
        execb = 1'b0; tsel = 1'b0; incp = 1'b0;
        expect_val("prio_pc", S_PC, 32'h12);
        expect_val("prio_br", S_BR, 32'h1);
        execb = 1'b1; tsel = 1'b0;
        tick();
        execb = 1'b0;
        expect_val("notsel_pc", S_PC, 32'h12);
        expect_val("notsel_br", S_BR, 32'h0);

        // Address mux and register select
        load_ir(16'hA0E5);
        msel = 1'b1; c_addr = 8'h40; nsel = 2'b00;
        expect_val("maddr_c", S_MADDR, 32'h40);
        expect_val("regnum_00", S_REG, 32'h0);
        tick();
        nsel = 2'b01; expect_val("regnum_01", S_REG, 32'h7); tick();
        nsel = 2'b10; expect_val("regnum_10", S_REG, 32'h5); tick();
        nsel = 2'b11; expect_val("regnum_11", S_REG, 32'h0); tick();
        msel = 1'b0; expect_val("maddr_pc2", S_MADDR, 32'h12); tick();

        // Instruction counter wrap
        while (icnt_m != 4'd15) load_ir(16'h0000);
        expect_val("icount_max", S_ICNT, 32'hF);
        load_ir(16'h0000);
        expect_val("icount_wrap", S_ICNT, 32'h0);
        expect_val("zero_ir_opcode", S_OPC, 32'h0);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 5 && q.size() > 0; k++) tick();
        if (q.size() > 0) begin
            checks_total++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
